tl45_wb_arbiter: RTL and testbench
==================================

Name: tl45_wb_arbiter

Overview:
- Two-master to one-slave Wishbone (pipelined, B4) arbiter for the TL45 core.
- Shares the single memory bus between instruction fetch (m0, the cached prefetch line-fill master) and the data memory stage (m1).
- Grant is held for a master's whole cycle (cyc-locked), so a 16-beat line fill is never interleaved with data accesses.
- A bus watchdog aborts a hung cycle with an error to the owning master.

Parameters:
- AW, 30, address width in words.
- DW, 32, data width.
- TIMEOUT, 1023, cycles with requests outstanding and no ack/err before abort; width = $clog2(TIMEOUT+1).
- OUTW, 5, outstanding-request counter width.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_m0_cyc, i_m0_stb, i_m0_we  in  1 each  master 0 (fetch) controls.
- i_m0_addr  in  AW  master 0 address.
- i_m0_data  in  DW  master 0 write data.
- i_m0_sel  in  DW/8  master 0 byte select.
- o_m0_ack, o_m0_stall, o_m0_err  out  1 each  master 0 responses.
- o_m0_data  out  DW  master 0 read data.
- i_m1_*, o_m1_*  same as m0  master 1 (data stage).
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  slave controls.
- o_wb_addr  out  AW  slave address.
- o_wb_data  out  DW  slave write data.
- o_wb_sel  out  DW/8  slave byte select.
- i_wb_ack, i_wb_stall, i_wb_err  in  1 each  slave responses.
- i_wb_data  in  DW  slave read data.
- o_owner  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 0 = none.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Clock and reset: one clock, i_clk. Reset is asynchronous and active-low on i_reset_n. All state registers (state, owner, outstanding count, watchdog, last_grant) are cleared asynchronously.
- States: IDLE, OWN0, OWN1, ABORT. Reset state is IDLE.
- Reset output values: o_wb_cyc = o_wb_stb = 0, o_owner = 0, o_timeout = 0, all master ack/err = 0, both master stalls = 1.
- IDLE:
  - Slave cyc/stb = 0; both masters see stall = 1, ack = err = 0.
  - Any mX_cyc high: register the grant and go to OWNx next cycle.
  - Both requesting: m1 wins (fixed priority).
  - Request-to-o_wb_cyc latency is 1 cycle.
- OWNx (slave side):
  - o_wb_cyc/stb/we/addr/data/sel are a combinational mux of master x.
- OWNx (master x side):
  - o_mx_stall = i_wb_stall; o_mx_ack = i_wb_ack; o_mx_err = i_wb_err.
- OWNx (other master):
  - stall = 1, ack = err = 0.
- Read data: o_m0_data = o_m1_data = i_wb_data always; ack qualifies it.
- Release from OWNx:
  - When i_mx_cyc = 0, o_wb_cyc drops in the same cycle.
  - Next state is OWNy if the other master is requesting, else IDLE. No bubble is required on handoff.
  - No other path leaves OWNx except the timeout.
- Outstanding counter, cleared on entering any OWN state:
  - +1 on o_wb_stb & !i_wb_stall.
  - -1 on i_wb_ack | i_wb_err.
  - Both in the same cycle: unchanged.
  - Saturates at 2^OUTW-1.
  - Never decrements below 0; a stray ack with a count of 0 is passed to the owner and ignored by the counter.
- Watchdog:
  - Counts cycles in OWNx while outstanding > 0 and !(ack | err).
  - Cleared on any ack/err or state change.
  - On reaching TIMEOUT, in the same cycle: assert o_mx_err = 1 and o_timeout = 1 for one cycle, force o_wb_cyc = o_wb_stb = 0, and go to ABORT.
- ABORT:
  - Slave cyc = 0; owner sees stall = 1, no ack/err.
  - Stays in ABORT until the aborted owner drops cyc, then goes to IDLE.
  - Late slave acks in ABORT are discarded.
- o_wb_we, addr, data and sel in IDLE/ABORT are don't-care but must be driven (drive master 0 values).
- Reset mid-cycle: o_wb_cyc drops immediately (asynchronous) and the FSM goes to IDLE.

Optional Feature:
- Macro: TL45_ARB_ROUND_ROBIN_EN.
- Defined: the IDLE/handoff tie-break uses a last_grant register (reset = m1). The master not granted most recently wins. last_grant updates on each OWN entry.
- Undefined: fixed priority, m1 over m0. No last_grant register is built.

Test Plan:
- m0 issues 16-beat burst addr 0x100..0x10F, slave ack 1 cycle after each stb, m1 idle -> o_owner = 01 one cycle after i_m0_cyc; 16 acks reach m0 only; o_m1_stall = 1 throughout; IDLE after m0 drops cyc.
- m0 and m1 raise cyc in the same cycle (macro off) -> o_owner = 10. m0 waits with stall = 1 and is granted in the cycle after m1 drops cyc, with no idle bubble.
- Same as the previous test with TL45_ARB_ROUND_ROBIN_EN, repeated 4 times -> grants alternate m1, m0, m1, m0.
- m1 single read, slave stalls 3 cycles then acks with 0xDEADBEEF -> o_m1_stall high 3 cycles; o_m1_ack = 1 with o_m1_data = 0xDEADBEEF; outstanding returns to 0.
- m0 read, slave never acks, TIMEOUT = 8 -> 8 cycles after the accept, o_m0_err = 1 and o_timeout = 1 for one cycle, o_wb_cyc = 0. FSM stays in ABORT until m0 drops cyc, then enters IDLE; a late i_wb_ack is not forwarded.
- Assert i_reset_n = 0 mid-burst with 3 outstanding -> o_wb_cyc = 0 asynchronously and o_owner = 0. After release, a new m1 request is granted normally.

Source files
------------

// File: rtl/tl45_wb_arbiter.sv
// Two-master to one-slave pipelined Wishbone arbiter with a cyc-locked grant and a bus watchdog.
// Optional macro TL45_ARB_ROUND_ROBIN_EN replaces the fixed m1-over-m0 tie-break with last-grant round robin.
module tl45_wb_arbiter #(
  parameter int AW      = 30,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023,
  parameter int OUTW    = 5
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_m0_cyc,
  input  logic            i_m0_stb,
  input  logic            i_m0_we,
  input  logic [AW-1:0]   i_m0_addr,
  input  logic [DW-1:0]   i_m0_data,
  input  logic [DW/8-1:0] i_m0_sel,
  output logic            o_m0_ack,
  output logic            o_m0_stall,
  output logic            o_m0_err,
  output logic [DW-1:0]   o_m0_data,
  input  logic            i_m1_cyc,
  input  logic            i_m1_stb,
  input  logic            i_m1_we,
  input  logic [AW-1:0]   i_m1_addr,
  input  logic [DW-1:0]   i_m1_data,
  input  logic [DW/8-1:0] i_m1_sel,
  output logic            o_m1_ack,
  output logic            o_m1_stall,
  output logic            o_m1_err,
  output logic [DW-1:0]   o_m1_data,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  output logic [DW/8-1:0] o_wb_sel,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic            i_wb_err,
  input  logic [DW-1:0]   i_wb_data,
  output logic [1:0]      o_owner,
  output logic            o_timeout
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, ABORT} state_t;

  state_t          r_state, w_next;
  logic            r_abortM1;
  logic [OUTW-1:0] r_outstanding, w_outstanding;
  logic [TW-1:0]   r_wdog, w_wdog;
  logic            w_own, w_sel1, w_ownCyc, w_ownStb, w_rsp, w_fire, w_accept, w_tieM1;

`ifdef TL45_ARB_ROUND_ROBIN_EN
  logic r_lastM1;

  assign w_tieM1 = !r_lastM1;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)                                 r_lastM1 <= 1'b1;
    else if (w_next != r_state && w_next == OWN0)   r_lastM1 <= 1'b0;
    else if (w_next != r_state && w_next == OWN1)   r_lastM1 <= 1'b1;
  end
`else
  assign w_tieM1 = 1'b1;
`endif

  assign w_own    = (r_state == OWN0) || (r_state == OWN1);
  assign w_sel1   = (r_state == OWN1);
  assign w_ownCyc = w_sel1 ? i_m1_cyc : i_m0_cyc;
  assign w_ownStb = w_sel1 ? i_m1_stb : i_m0_stb;
  assign w_rsp    = i_wb_ack | i_wb_err;
  // Fires in the cycle the watchdog would count its TIMEOUT-th silent cycle.
  assign w_fire   = w_own && (r_outstanding != '0) && !w_rsp && (r_wdog == TW'(TIMEOUT - 1));

  assign o_wb_cyc  = w_own & w_ownCyc & !w_fire;
  assign o_wb_stb  = o_wb_cyc & w_ownStb;
  assign o_wb_we   = w_sel1 ? i_m1_we   : i_m0_we;
  assign o_wb_addr = w_sel1 ? i_m1_addr : i_m0_addr;
  assign o_wb_data = w_sel1 ? i_m1_data : i_m0_data;
  assign o_wb_sel  = w_sel1 ? i_m1_sel  : i_m0_sel;
  assign w_accept  = o_wb_stb & !i_wb_stall;

  assign o_m0_stall = (r_state != OWN0) | i_wb_stall | w_fire;
  assign o_m0_ack   = (r_state == OWN0) & i_wb_ack;
  assign o_m0_err   = (r_state == OWN0) & (i_wb_err | w_fire);
  assign o_m1_stall = (r_state != OWN1) | i_wb_stall | w_fire;
  assign o_m1_ack   = (r_state == OWN1) & i_wb_ack;
  assign o_m1_err   = (r_state == OWN1) & (i_wb_err | w_fire);
  assign o_m0_data  = i_wb_data;
  assign o_m1_data  = i_wb_data;
  assign o_owner    = {r_state == OWN1, r_state == OWN0};
  assign o_timeout  = w_fire;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_m1_cyc && (w_tieM1 || !i_m0_cyc)) w_next = OWN1;
        else if (i_m0_cyc)                      w_next = OWN0;
      end
      OWN0: begin
        if (w_fire)         w_next = ABORT;
        else if (!i_m0_cyc) w_next = i_m1_cyc ? OWN1 : IDLE;
      end
      OWN1: begin
        if (w_fire)         w_next = ABORT;
        else if (!i_m1_cyc) w_next = i_m0_cyc ? OWN0 : IDLE;
      end
      ABORT: begin
        if (!(r_abortM1 ? i_m1_cyc : i_m0_cyc)) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Stray acks at a zero count pass to the owner but never underflow the counter.
  always_comb begin
    w_outstanding = r_outstanding;
    w_wdog        = '0;
    if (w_next != r_state) begin
      w_outstanding = '0;
    end else if (w_own) begin
      if (w_accept && !w_rsp) begin
        if (r_outstanding != '1) w_outstanding = r_outstanding + 1'b1;
      end else if (!w_accept && w_rsp && r_outstanding != '0) begin
        w_outstanding = r_outstanding - 1'b1;
      end
      if (!w_rsp) w_wdog = (r_outstanding != '0) ? r_wdog + 1'b1 : r_wdog;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= IDLE;
      r_abortM1     <= 1'b0;
      r_outstanding <= '0;
      r_wdog        <= '0;
    end else begin
      r_state       <= w_next;
      r_outstanding <= w_outstanding;
      r_wdog        <= w_wdog;
      if (w_fire) r_abortM1 <= w_sel1;
    end
  end

endmodule

// File: tb/tb_tl45_wb_arbiter.sv
// Self-checking bench for tl45_wb_arbiter: directed scenarios plus random traffic against a behavioural model.
module tb_tl45_wb_arbiter;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0Cyc, m0Stb, m0We, m1Cyc, m1Stb, m1We;
  logic [29:0] m0Addr, m1Addr;
  logic [31:0] m0Data, m1Data, wbData;
  logic [3:0]  m0Sel, m1Sel;
  logic        wbAck, wbStall, wbErr;

  logic        m0AckO, m0StallO, m0ErrO, m1AckO, m1StallO, m1ErrO;
  logic [31:0] m0DataO, m1DataO, wbDataO;
  logic        wbCycO, wbStbO, wbWeO, timeoutO;
  logic [29:0] wbAddrO;
  logic [3:0]  wbSelO;
  logic [1:0]  ownerO;

  int nVectors = 0;
  int nMiscompares = 0;

  // Model state: owner 0 = none, 1 = m0, 2 = m1; pending = accepted but unanswered requests.
  int  mOwner, mPending, mWait, mLast, nOwner, nPending, nWait, nLast;
  bit  mAbort, nAbort;
  logic       eWbCyc, eWbStb, eWe, eTimeout;
  logic [1:0] eOwner, eAck, eStall, eErr;
  logic [29:0] eAddr;
  logic [31:0] eData;
  logic [3:0]  eSel;

  tl45_wb_arbiter #(.AW(30), .DW(32), .TIMEOUT(TO), .OUTW(5)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_m0_cyc(m0Cyc), .i_m0_stb(m0Stb), .i_m0_we(m0We), .i_m0_addr(m0Addr),
    .i_m0_data(m0Data), .i_m0_sel(m0Sel),
    .o_m0_ack(m0AckO), .o_m0_stall(m0StallO), .o_m0_err(m0ErrO), .o_m0_data(m0DataO),
    .i_m1_cyc(m1Cyc), .i_m1_stb(m1Stb), .i_m1_we(m1We), .i_m1_addr(m1Addr),
    .i_m1_data(m1Data), .i_m1_sel(m1Sel),
    .o_m1_ack(m1AckO), .o_m1_stall(m1StallO), .o_m1_err(m1ErrO), .o_m1_data(m1DataO),
    .o_wb_cyc(wbCycO), .o_wb_stb(wbStbO), .o_wb_we(wbWeO), .o_wb_addr(wbAddrO),
    .o_wb_data(wbDataO), .o_wb_sel(wbSelO),
    .i_wb_ack(wbAck), .i_wb_stall(wbStall), .i_wb_err(wbErr), .i_wb_data(wbData),
    .o_owner(ownerO), .o_timeout(timeoutO)
  );

  always #5 clk = ~clk;

  function automatic logic [141:0] actVec();
    return {wbCycO, wbStbO, wbWeO, ownerO, timeoutO, m0AckO, m0StallO, m0ErrO,
            m1AckO, m1StallO, m1ErrO, wbAddrO, wbDataO, wbSelO, m0DataO, m1DataO};
  endfunction

  function automatic logic [141:0] expVec();
    return {eWbCyc, eWbStb, eWe, eOwner, eTimeout, eAck[0], eStall[0], eErr[0],
            eAck[1], eStall[1], eErr[1], eAddr, eData, eSel, wbData, wbData};
  endfunction

  function automatic int tieWinner();
`ifdef TL45_ARB_ROUND_ROBIN_EN
    return (mLast == 2) ? 1 : 2;
`else
    return 2;
`endif
  endfunction

  task automatic modelReset();
    mOwner = 0; mAbort = 0; mPending = 0; mWait = 0; mLast = 2;
  endtask

  task automatic modelCommit();
    mOwner = nOwner; mAbort = nAbort; mPending = nPending; mWait = nWait; mLast = nLast;
  endtask

  // Predict this cycle's outputs from the current inputs, and the state after the next edge.
  task automatic modelEval();
    logic [1:0] cyc, stb;
    logic rsp, tmo, acc;
    int x;
    cyc = {m1Cyc, m0Cyc};
    stb = {m1Stb, m0Stb};
    rsp = wbAck | wbErr;
    eWbCyc = 0; eWbStb = 0; eTimeout = 0; eOwner = 0; eAck = 0; eErr = 0; eStall = 2'b11;
    {eWe, eAddr, eData, eSel} = {m0We, m0Addr, m0Data, m0Sel};
    nOwner = mOwner; nAbort = mAbort; nPending = mPending; nWait = 0; nLast = mLast;
    if (mOwner == 0) begin
      if (cyc == 2'b11) nOwner = tieWinner();
      else if (cyc[1])  nOwner = 2;
      else if (cyc[0])  nOwner = 1;
    end else if (mAbort) begin
      if (!cyc[mOwner-1]) begin nOwner = 0; nAbort = 0; end
    end else begin
      x = mOwner - 1;
      tmo = (mPending > 0) && !rsp && (mWait + 1 == TO);
      if (x == 1) {eWe, eAddr, eData, eSel} = {m1We, m1Addr, m1Data, m1Sel};
      eOwner[x] = 1'b1;
      eWbCyc    = cyc[x] && !tmo;
      eWbStb    = eWbCyc && stb[x];
      eStall[x] = wbStall || tmo;
      eAck[x]   = wbAck;
      eErr[x]   = wbErr || tmo;
      eTimeout  = tmo;
      acc = eWbStb && !wbStall;
      if (tmo) nAbort = 1;
      else if (!cyc[x]) nOwner = cyc[1-x] ? 2 - x : 0;
      if (nOwner == mOwner && !nAbort) begin
        if (acc && !rsp) nPending = (mPending < 31) ? mPending + 1 : mPending;
        else if (!acc && rsp && mPending > 0) nPending = mPending - 1;
        nWait = rsp ? 0 : ((mPending > 0) ? mWait + 1 : mWait);
      end
    end
    if (nOwner != 0 && nOwner != mOwner) begin nPending = 0; nLast = nOwner; end
  endtask

  task automatic settle();
    #3;
    modelEval();
  endtask

  task automatic advance();
    @(posedge clk);
    modelCommit();
    #1;
  endtask

  task automatic zeroInputs();
    {m0Cyc, m0Stb, m0We, m1Cyc, m1Stb, m1We} = '0;
    m0Addr = '0; m1Addr = '0; m0Data = '0; m1Data = '0; m0Sel = '0; m1Sel = '0;
    wbAck = 0; wbStall = 0; wbErr = 0; wbData = '0;
  endtask

  task automatic test_reset();
    m0Cyc = 1; m1Cyc = 1;
    for (int k = 0; k < 2; k++) begin
      #3;
      nVectors++;
      if ({wbCycO, wbStbO, ownerO, timeoutO, m0AckO, m0ErrO, m1AckO, m1ErrO, m0StallO, m1StallO} !== 10'b0000000011) begin
        nMiscompares++;
        $display("[TB] FAIL reset_outputs: got %b want %b",
                 {wbCycO, wbStbO, ownerO, timeoutO, m0AckO, m0ErrO, m1AckO, m1ErrO, m0StallO, m1StallO}, 10'b0000000011);
      end
      @(posedge clk); #1;
    end
    zeroInputs();
    @(posedge clk); #1;
  endtask

  task automatic test_burst();
    int beat = 0, acks = 0;
    logic ackNext = 0;
    for (int c = 0; c < 20; c++) begin
      m0Cyc = (beat < 16) || ackNext;
      m0Stb = (beat < 16);
      m0Addr = 30'h100 + 30'(beat);
      m0Data = $urandom; m0Sel = 4'hF; m0We = 1;
      wbAck = ackNext; wbStall = 0; wbData = $urandom;
      settle();
      nVectors++;
      if (actVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL burst_cycle%0d: got %h want %h", c, actVec(), expVec());
      end
      if (c == 1) begin
        nVectors++;
        if (ownerO !== 2'b01) begin
          nMiscompares++;
          $display("[TB] FAIL burst_grant_latency: owner %b want 01", ownerO);
        end
      end
      if (m0AckO) acks++;
      ackNext = eWbStb && !wbStall;
      if (ackNext) beat++;
      advance();
    end
    nVectors++;
    if (acks !== 16 || ownerO !== 2'b00) begin
      nMiscompares++;
      $display("[TB] FAIL burst_acks_release: acks %0d owner %b want 16 and 00", acks, ownerO);
    end
    zeroInputs();
  endtask

  task automatic test_tie_break(input int reps);
    int rem[2], pend[2], dropCyc, w;
    logic [1:0] expWin;
    logic ackNext;
    for (int r = 0; r < reps; r++) begin
      rem[0] = 2; rem[1] = 2; pend[0] = 0; pend[1] = 0; dropCyc = -1; ackNext = 0;
      expWin = (tieWinner() == 2) ? 2'b10 : 2'b01;
      w = expWin[1] ? 1 : 0;
      for (int c = 0; c < 14; c++) begin
        m0Cyc = (rem[0] > 0) || (pend[0] > 0); m0Stb = (rem[0] > 0);
        m1Cyc = (rem[1] > 0) || (pend[1] > 0); m1Stb = (rem[1] > 0);
        m0Addr = 30'($urandom); m1Addr = 30'($urandom);
        m0Data = $urandom; m1Data = $urandom; m0Sel = 4'($urandom); m1Sel = 4'($urandom);
        m0We = 1'($urandom); m1We = 1'($urandom);
        wbAck = ackNext; wbStall = 0; wbData = $urandom;
        settle();
        nVectors++;
        if (actVec() !== expVec()) begin
          nMiscompares++;
          $display("[TB] FAIL tie_rep%0d_cycle%0d: got %h want %h", r, c, actVec(), expVec());
        end
        if (c == 1) begin
          nVectors++;
          if (ownerO !== expWin) begin
            nMiscompares++;
            $display("[TB] FAIL tie_winner_rep%0d: owner %b want %b", r, ownerO, expWin);
          end
        end
        if (dropCyc >= 0 && c == dropCyc + 1) begin
          nVectors++;
          if (ownerO !== ~expWin) begin
            nMiscompares++;
            $display("[TB] FAIL tie_handoff_rep%0d: owner %b want %b", r, ownerO, ~expWin);
          end
        end
        if (dropCyc < 0 && c > 0 && !(w == 1 ? m1Cyc : m0Cyc)) dropCyc = c;
        for (int k = 0; k < 2; k++) if (eAck[k] && pend[k] > 0) pend[k]--;
        ackNext = eWbStb && !wbStall;
        if (ackNext) begin
          rem[mOwner-1]--;
          pend[mOwner-1]++;
        end
        advance();
      end
      zeroInputs();
    end
  endtask

  task automatic test_stall_read();
    int stalls = 0, pulses = 0;
    for (int c = 0; c < 20; c++) begin
      m1Cyc = (c <= 17); m1Stb = (c <= 4); m1We = 0;
      m1Addr = 30'h2A0; m1Sel = 4'hF; m1Data = $urandom;
      wbStall = (c >= 1 && c <= 3); wbAck = (c == 5);
      wbData = (c == 5) ? 32'hDEADBEEF : $urandom;
      settle();
      nVectors++;
      if (actVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL stall_read_cycle%0d: got %h want %h", c, actVec(), expVec());
      end
      if (c >= 1 && c <= 4 && m1StallO) stalls++;
      if (timeoutO) pulses++;
      if (c == 5) begin
        nVectors++;
        if (m1AckO !== 1'b1 || m1DataO !== 32'hDEADBEEF) begin
          nMiscompares++;
          $display("[TB] FAIL stall_read_ack: ack %b data %h want 1 deadbeef", m1AckO, m1DataO);
        end
      end
      advance();
    end
    nVectors++;
    if (stalls !== 3 || pulses !== 0) begin
      nMiscompares++;
      $display("[TB] FAIL stall_read_counts: stalls %0d timeouts %0d want 3 and 0", stalls, pulses);
    end
    zeroInputs();
  endtask

  task automatic test_timeout();
    int fireCyc = -1, pulses = 0, lateAcks = 0;
    for (int c = 0; c < 16; c++) begin
      m0Cyc = (c <= 13); m0Stb = (c <= 1); m0We = 0; m0Addr = 30'h3C0;
      wbStall = 0; wbAck = (c >= 10 && c <= 13); wbData = $urandom;
      settle();
      nVectors++;
      if (actVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL timeout_cycle%0d: got %h want %h", c, actVec(), expVec());
      end
      if (fireCyc < 0 && m0ErrO) begin
        fireCyc = c;
        nVectors++;
        if (timeoutO !== 1'b1 || wbCycO !== 1'b0) begin
          nMiscompares++;
          $display("[TB] FAIL timeout_fire: timeout %b cyc %b want 1 0", timeoutO, wbCycO);
        end
      end
      if (timeoutO) pulses++;
      if (c >= 10 && m0AckO) lateAcks++;
      advance();
    end
    nVectors++;
    if (fireCyc !== 9 || pulses !== 1 || lateAcks !== 0 || ownerO !== 2'b00) begin
      nMiscompares++;
      $display("[TB] FAIL timeout_summary: fire cycle %0d pulses %0d late acks %0d owner %b want 9 1 0 00",
               fireCyc, pulses, lateAcks, ownerO);
    end
    zeroInputs();
  endtask

  task automatic test_reset_mid();
    for (int c = 0; c < 5; c++) begin
      m0Cyc = 1; m0Stb = 1; m0Addr = 30'h500 + 30'(c); wbStall = 0; wbAck = 0;
      settle();
      nVectors++;
      if (actVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL reset_mid_cycle%0d: got %h want %h", c, actVec(), expVec());
      end
      if (c < 4) advance();
    end
    #2 rst_n = 0;
    #1;
    nVectors++;
    if (wbCycO !== 1'b0 || ownerO !== 2'b00) begin
      nMiscompares++;
      $display("[TB] FAIL reset_mid_async: cyc %b owner %b want 0 00", wbCycO, ownerO);
    end
    zeroInputs();
    @(posedge clk); #1;
    modelReset();
    rst_n = 1;
    for (int c = 0; c < 4; c++) begin
      m1Cyc = (c <= 2); m1Stb = (c == 1); m1Addr = 30'h77;
      wbAck = (c == 2);
      settle();
      nVectors++;
      if (actVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL reset_mid_after_cycle%0d: got %h want %h", c, actVec(), expVec());
      end
      if (c == 1) begin
        nVectors++;
        if (ownerO !== 2'b10) begin
          nMiscompares++;
          $display("[TB] FAIL reset_mid_regrant: owner %b want 10", ownerO);
        end
      end
      advance();
    end
    zeroInputs();
  endtask

  task automatic test_random();
    logic quiet;
    for (int c = 0; c < 800; c++) begin
      quiet = ((c % 150) >= 128);
      if (m0Cyc) m0Cyc = ($urandom_range(7) != 0); else m0Cyc = ($urandom_range(3) == 0);
      if (m1Cyc) m1Cyc = ($urandom_range(7) != 0); else m1Cyc = ($urandom_range(3) == 0);
      m0Stb = m0Cyc && 1'($urandom); m1Stb = m1Cyc && 1'($urandom);
      m0We = 1'($urandom); m1We = 1'($urandom);
      m0Addr = 30'($urandom); m1Addr = 30'($urandom);
      m0Data = $urandom; m1Data = $urandom; m0Sel = 4'($urandom); m1Sel = 4'($urandom);
      wbStall = ($urandom_range(3) == 0);
      wbAck = !quiet && ($urandom_range(2) == 0);
      wbErr = !quiet && ($urandom_range(15) == 0);
      wbData = $urandom;
      settle();
      nVectors++;
      if (actVec() !== expVec()) begin
        nMiscompares++;
        $display("[TB] FAIL random_cycle%0d: got %h want %h", c, actVec(), expVec());
      end
      advance();
    end
    zeroInputs();
    repeat (2) begin settle(); advance(); end
  endtask

  initial begin
    zeroInputs();
    rst_n = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1;
    test_burst();
    test_tie_break(1);
    test_tie_break(4);
    test_stall_read();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
